// File: rtl/instr_assembler.sv
// Packs an opcode class, register fields, function fields and a full signed
// immediate into an RV32I instruction word, then streams the words with
// ascending byte addresses through a single registered output stage.
module instr_assembler #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  input  logic              clr_err,
  output logic [15:0]       instr_count
);

  // Major opcode classes, instruction bits [6:2]
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [31:0]       NOP_WORD  = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  logic [6:0]  opcode;
  logic        isShift;
  logic        iRangeOk;
  logic        shiftRangeOk;
  logic        bRangeOk;
  logic        uRangeOk;
  logic        jRangeOk;
  logic [31:0] rawWord;
  logic        immOk;
  logic        opKnown;
  logic [31:0] encWord;
  logic        encErr;

  logic              outValid_q, outValid_d;
  logic [31:0]       outInstr_q, outInstr_d;
  logic [ADDR_W-1:0] outAddr_q, outAddr_d;
  logic              outErr_q, outErr_d;
  logic [ADDR_W-1:0] nextAddr_q, nextAddr_d;
  logic              errSticky_q, errSticky_d;
  logic [15:0]       count_q, count_d;

  logic accept;
  logic handoff;

  assign opcode  = {in_op, 2'b11};
  assign isShift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // The immediate must be reproducible by the decoder: the bits above the
  // encoded field have to be a pure sign extension, and bits the format
  // drops (low zeros for branches/jumps, low 12 for U) must be zero.
  assign iRangeOk     = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign shiftRangeOk = ~(|in_imm[31:5]);
  assign bRangeOk     = ~in_imm[0] & ((&in_imm[31:12]) | ~(|in_imm[31:12]));
  assign uRangeOk     = ~(|in_imm[11:0]);
  assign jRangeOk     = ~in_imm[0] & ((&in_imm[31:20]) | ~(|in_imm[31:20]));

  // Format-specific bit scatter and legality; any failure becomes a NOP
  always_comb begin
    rawWord = '0;
    immOk   = 1'b0;
    opKnown = 1'b1;
    case (in_op)
      OP_LOAD, OP_JALR: begin
        rawWord = {in_imm[11:0], in_rs1, in_funct3, in_rd, opcode};
        immOk   = iRangeOk;
      end
      OP_OPIMM: begin
        if (isShift) begin
          rawWord = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, opcode};
          immOk   = shiftRangeOk;
        end else begin
          rawWord = {in_imm[11:0], in_rs1, in_funct3, in_rd, opcode};
          immOk   = iRangeOk;
        end
      end
      OP_STORE: begin
        rawWord = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], opcode};
        immOk   = iRangeOk;
      end
      OP_BRANCH: begin
        rawWord = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], opcode};
        immOk   = bRangeOk;
      end
      OP_LUI, OP_AUIPC: begin
        rawWord = {in_imm[31:12], in_rd, opcode};
        immOk   = uRangeOk;
      end
      OP_JAL: begin
        rawWord = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opcode};
        immOk   = jRangeOk;
      end
      OP_OP: begin
        rawWord = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, opcode};
        immOk   = 1'b1;
      end
      default: begin
        opKnown = 1'b0;
      end
    endcase
    encErr  = ~(opKnown & immOk);
    encWord = encErr ? NOP_WORD : rawWord;
  end

  // The output stage can take a new word whenever it is empty or draining
  assign in_ready = ~outValid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign handoff  = outValid_q & out_ready;

  // Next-state for the output register, address counter, error flag and
  // handoff counter; a stalled word simply keeps its previous contents
  always_comb begin
    outValid_d  = outValid_q;
    outInstr_d  = outInstr_q;
    outAddr_d   = outAddr_q;
    outErr_d    = outErr_q;
    nextAddr_d  = nextAddr_q;
    errSticky_d = errSticky_q;
    count_d     = count_q;

    if (accept) begin
      outValid_d = 1'b1;
      outInstr_d = encWord;
      outAddr_d  = nextAddr_q;
      outErr_d   = encErr;
      nextAddr_d = nextAddr_q + ADDR_STEP;
    end else if (handoff) begin
      outValid_d = 1'b0;
    end

    if (handoff) begin
      count_d = count_q + 16'd1;
    end

    if (accept && encErr) begin
      errSticky_d = 1'b1;
    end else if (clr_err) begin
      errSticky_d = 1'b0;
    end
  end

  // State registers; reset drops any pending word and restarts addressing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q  <= 1'b0;
      outInstr_q  <= '0;
      outAddr_q   <= BASE_ADDR;
      outErr_q    <= 1'b0;
      nextAddr_q  <= BASE_ADDR;
      errSticky_q <= 1'b0;
      count_q     <= '0;
    end else begin
      outValid_q  <= outValid_d;
      outInstr_q  <= outInstr_d;
      outAddr_q   <= outAddr_d;
      outErr_q    <= outErr_d;
      nextAddr_q  <= nextAddr_d;
      errSticky_q <= errSticky_d;
      count_q     <= count_d;
    end
  end

  assign out_valid   = outValid_q;
  assign out_instr   = outInstr_q;
  assign out_addr    = outAddr_q;
  assign out_err     = outErr_q;
  assign err_sticky  = errSticky_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Scoreboard bench for instr_assembler: expected words are queued when a
// request is accepted and compared as the DUT hands them off.
module tb_instr_assembler;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_sticky;
  logic        clr_err;
  logic [15:0] instr_count;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        expQ[$];
  vec_t        legalTab[$];
  vec_t        errTab[$];
  logic [31:0] addrModel;
  logic [15:0] handoffs;
  int          totalChecks;
  int          badChecks;

  instr_assembler #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_sticky(err_sticky), .clr_err(clr_err), .instr_count(instr_count)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic [31:0] instr,
                              input logic err);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.instr = instr; v.err = err;
    return v;
  endfunction

  // Drive one request (at posedge+1), wait for acceptance, record expectation
  task automatic applyStimulus(input vec_t v);
    int n;
    in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
    end else begin
      expQ.push_back('{instr: v.instr, addr: addrModel, err: v.err});
      addrModel = addrModel + 32'd4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("drainTimeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    expQ.delete();
    addrModel = BASE;
    handoffs  = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: a handoff happens at the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousWord", out_instr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("instr", out_instr, e.instr);
        checkOutput("addr", out_addr, e.addr);
        checkOutput("err", {31'd0, out_err}, {31'd0, e.err});
      end
      handoffs = handoffs + 16'd1;
    end
  end

  initial begin
    vec_t bpA;
    vec_t bpB;
    logic [31:0] bpAddr;
    totalChecks = 0;
    badChecks   = 0;
    addrModel   = BASE;
    handoffs    = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;

    legalTab.push_back(mk(5'b01000, 5'd9, 5'd1, 5'd2, 3'b010, 7'h00, 32'd8,        32'h0020A423, 1'b0));
    legalTab.push_back(mk(5'b11000, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0));
    legalTab.push_back(mk(5'b11011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h00000800, 32'h001000EF, 1'b0));
    legalTab.push_back(mk(5'b01101, 5'd5, 5'd7, 5'd3, 3'b111, 7'h7F, 32'h12345000, 32'h123452B7, 1'b0));
    legalTab.push_back(mk(5'b00000, 5'd3, 5'd2, 5'd0, 3'b010, 7'h00, 32'hFFFFFFFC, 32'hFFC12183, 1'b0));
    legalTab.push_back(mk(5'b00100, 5'd1, 5'd1, 5'd0, 3'b001, 7'h00, 32'd3,        32'h00309093, 1'b0));
    legalTab.push_back(mk(5'b00100, 5'd1, 5'd1, 5'd0, 3'b101, 7'h20, 32'd3,        32'h4030D093, 1'b0));
    legalTab.push_back(mk(5'b01100, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'hDEADBEEF, 32'h002081B3, 1'b0));
    legalTab.push_back(mk(5'b01100, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'd0,        32'h402081B3, 1'b0));
    legalTab.push_back(mk(5'b00101, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFFF000, 32'hFFFFF097, 1'b0));
    legalTab.push_back(mk(5'b11001, 5'd0, 5'd1, 5'd0, 3'b000, 7'h00, 32'd0,        32'h00008067, 1'b0));
    legalTab.push_back(mk(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0));
    legalTab.push_back(mk(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2047,     32'h7FF00093, 1'b0));
    legalTab.push_back(mk(5'b11000, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'h00000FFE, 32'h7E000FE3, 1'b0));
    legalTab.push_back(mk(5'b11011, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFFFFFE, 32'hFFFFF06F, 1'b0));

    errTab.push_back(mk(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd4096,     32'h00000013, 1'b1));
    errTab.push_back(mk(5'b11000, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'd3,        32'h00000013, 1'b1));
    errTab.push_back(mk(5'b11111, 5'd1, 5'd2, 5'd3, 3'b000, 7'h00, 32'd0,        32'h00000013, 1'b1));
    errTab.push_back(mk(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048,     32'h00000013, 1'b1));
    errTab.push_back(mk(5'b00100, 5'd1, 5'd1, 5'd0, 3'b001, 7'h00, 32'd32,       32'h00000013, 1'b1));
    errTab.push_back(mk(5'b01101, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h12345001, 32'h00000013, 1'b1));
    errTab.push_back(mk(5'b11011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h00100000, 32'h00000013, 1'b1));
    errTab.push_back(mk(5'b01000, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'hFFFFF7FF, 32'h00000013, 1'b1));

    // Reset state while reset is held
    #12;
    checkOutput("rstValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstInstr", out_instr, 32'd0);
    checkOutput("rstAddr", out_addr, BASE);
    checkOutput("rstErr", {31'd0, out_err}, 32'd0);
    checkOutput("rstSticky", {31'd0, err_sticky}, 32'd0);
    checkOutput("rstCount", {16'd0, instr_count}, 32'd0);
    checkOutput("rstReady", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single ADDI, then confirm the handoff counter
    applyStimulus(mk(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 32'h00500093, 1'b0));
    checkOutput("addiValid", {31'd0, out_valid}, 32'd1);
    waitDrain();
    checkOutput("countAfterAddi", {16'd0, instr_count}, 32'd1);

    // Legal words streamed back to back
    foreach (legalTab[i]) applyStimulus(legalTab[i]);
    waitDrain();
    checkOutput("stickyLegal", {31'd0, err_sticky}, 32'd0);

    // Each error word sets the sticky flag; a clear pulse drops it again
    foreach (errTab[i]) begin
      applyStimulus(errTab[i]);
      checkOutput("stickySet", {31'd0, err_sticky}, 32'd1);
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      checkOutput("stickyCleared", {31'd0, err_sticky}, 32'd0);
    end
    waitDrain();

    // Clear coinciding with a new error: set must win
    clr_err = 1'b1;
    applyStimulus(errTab[0]);
    clr_err = 1'b0;
    checkOutput("stickySetWins", {31'd0, err_sticky}, 32'd1);
    waitDrain();

    // Backpressure: word A stalls, word B waits with in_valid held high
    bpA = legalTab[7];
    bpB = legalTab[8];
    out_ready = 1'b0;
    bpAddr = addrModel;
    applyStimulus(bpA);
    in_op = bpB.op; in_rd = bpB.rd; in_rs1 = bpB.rs1; in_rs2 = bpB.rs2;
    in_funct3 = bpB.f3; in_funct7 = bpB.f7; in_imm = bpB.imm;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bpReady", {31'd0, in_ready}, 32'd0);
      checkOutput("bpValid", {31'd0, out_valid}, 32'd1);
      checkOutput("bpInstrHeld", out_instr, bpA.instr);
      checkOutput("bpAddrHeld", out_addr, bpAddr);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(bpB);
    waitDrain();
    checkOutput("countBeforeReset", {16'd0, instr_count}, {16'd0, handoffs});

    // Asynchronous reset with a stalled word at address 0x8
    applyReset();
    applyStimulus(legalTab[0]);
    applyStimulus(legalTab[1]);
    waitDrain();
    out_ready = 1'b0;
    applyStimulus(legalTab[2]);
    checkOutput("preRstAddr", out_addr, BASE + 32'h8);
    checkOutput("preRstValid", {31'd0, out_valid}, 32'd1);
    #3;
    rst = 1'b1;
    expQ.delete();
    addrModel = BASE;
    handoffs  = '0;
    #1;
    checkOutput("asyncRstValid", {31'd0, out_valid}, 32'd0);
    checkOutput("asyncRstCount", {16'd0, instr_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    applyStimulus(legalTab[3]);
    waitDrain();
    checkOutput("countAfterReset", {16'd0, instr_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Inverse of the decode-side immediate generator: packs an opcode class, register fields, function fields and a full 32-bit signed immediate into an RV32I instruction word.
- Scatters immediate bits per format: I/S/B/U/J/R.
- Range-checks the immediate against the format.
- Streams assembled words with word addresses into instruction memory through valid/ready handshakes.
- Used by the boot loader and test-program injector for the single-cycle core.

Parameters:
BASE_ADDR, 32'h0000_0000, address tagged on the first output word after reset
ADDR_W, 32, width of out_addr

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_op  in  5  instruction bits [6:2]; bits [1:0] always emitted as 2'b11
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R-type and OP-IMM shifts)
in_imm  in  32  full signed immediate value as the decoder would reproduce it
out_valid  out  1  output word valid
out_ready  in  1  consumer ready
out_instr  out  32  assembled instruction
out_addr  out  ADDR_W  byte address of out_instr
out_err  out  1  this word replaced due to encode error
err_sticky  out  1  set by any error, cleared by clr_err
clr_err  in  1  synchronous clear of err_sticky
instr_count  out  16  number of words handed off (out_valid & out_ready), wraps

Behaviour:
- Reset (async, rst=1), all outputs:
  - out_valid=0, out_instr=0, out_err=0, err_sticky=0, instr_count=0.
  - out_addr=BASE_ADDR.
  - Internal next-address register = BASE_ADDR.
- Single registered output stage.
  - in_ready = ~out_valid | out_ready (combinational).
  - Latency: 1 cycle from accept to out_valid.
  - Full throughput of one word per cycle when out_ready=1.
- Output hold: while out_valid & ~out_ready, out_instr/out_addr/out_err are held stable.
- Accept (in_valid & in_ready), next edge:
  - Output register loads the encoded word and out_addr = next-address.
  - next-address += 4 (wraps mod 2^ADDR_W).
  - out_valid=1.
- Handoff without new accept: out_valid -> 0.
- Handoff: instr_count increments on every out_valid & out_ready, wrapping 0xFFFF -> 0.
- Encoding by in_op:
  - 00000 LOAD, 00100 OP-IMM, 11001 JALR (I-type): imm[11:0] -> [31:20]. Legal if in_imm[31:11] all equal.
  - OP-IMM with funct3 001/101 (shifts): [31:25]=in_funct7, [24:20]=in_imm[4:0]. Legal if in_imm[31:5]=0.
  - 01000 STORE (S-type): imm[11:5] -> [31:25], imm[4:0] -> [11:7]. Same range as I.
  - 11000 BRANCH (B-type): imm[12] -> [31], imm[10:5] -> [30:25], imm[4:1] -> [11:8], imm[11] -> [7]. Legal if in_imm[0]=0 and in_imm[31:12] all equal.
  - 01101 LUI, 00101 AUIPC (U-type): in_imm[31:12] -> [31:12]. Legal if in_imm[11:0]=0.
  - 11011 JAL (J-type): imm[20] -> [31], imm[10:1] -> [30:21], imm[11] -> [20], imm[19:12] -> [19:12]. Legal if in_imm[0]=0 and in_imm[31:20] all equal.
  - 01100 OP (R-type): in_funct7 -> [31:25]; in_imm ignored; always legal.
- Field usage:
  - rd -> [11:7] for I/U/J/R.
  - rs1 -> [19:15] for I/S/B/R.
  - rs2 -> [24:20] for S/B/R.
  - funct3 -> [14:12] for I/S/B/R.
  - Fields unused by the format are forced to 0.
- Error handling: any other in_op, or an illegal immediate, produces a word anyway:
  - out_instr = 32'h0000_0013 (NOP), out_err=1.
  - Address still advances.
  - err_sticky set on the accept edge.
- Simultaneous clr_err and new error on the same edge: set wins (err_sticky=1).
- Reset mid-operation: a pending output word is discarded and not counted; addressing restarts at BASE_ADDR.

Test Plan:
- ADDI x1,x0,5 (op 00100, rd 1, rs1 0, f3 000, imm 5), out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_addr=0x0, out_err=0; instr_count=1 after handoff.
- Back-to-back SW x2,8(x1) (op 01000, rs1 1, rs2 2, f3 010, imm 8) then BEQ x0,x0,-4 (op 11000, imm 0xFFFFFFFC) -> 0x0020A423 @0x0, 0xFE000EE3 @0x4 on consecutive cycles.
- JAL x1,+2048 (op 11011, rd 1, imm 0x800) -> 0x001000EF; LUI x5,0x12345000 (op 01101, rd 5) -> 0x123452B7.
- Errors:
  - ADDI imm=4096 -> out_instr=0x00000013, out_err=1, err_sticky=1.
  - BEQ imm=3 (odd) -> same.
  - in_op=11111 -> same.
  - clr_err pulse -> err_sticky=0.
  - clr_err coincident with new error -> err_sticky stays 1.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 while out_valid=1, out_instr/out_addr stable; on release, next word follows with addr +4 and no loss or duplication.
- Async reset: assert rst mid-cycle with out_valid=1 and out_addr=0x8 -> immediately out_valid=0, instr_count=0; next accepted word tagged BASE_ADDR.
